uart_rx: RTL
============

# uart_rx

Serial-to-parallel UART receiver, the receive-side counterpart of the team's UART transmitter. Recovers frames of the form start(0), 8 data bits LSB first, optional parity, stop(1) from an oversampled line. Presents each good byte on `P_DATA` with a one-cycle `DATA_VALID` strobe, and flags parity and stop errors. Parity and framing conventions match the transmitter, so a TX→RX loopback is bit-exact.

## Interface
- `PRESCALE`, default 8: clocks per bit period. Even, ≥4.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `RX_IN` input 1: serial line, idles high, asynchronous to `clk`.
- `PAR_EN` input 1: 1 = frame carries a parity bit.
- `PAR_TYP` input 1: 0 = even parity, 1 = odd parity.
- `P_DATA` output 8: last good received byte.
- `DATA_VALID` output 1: one-cycle pulse when `P_DATA` is updated.
- `PAR_ERR` output 1: one-cycle pulse, parity mismatch.
- `STP_ERR` output 1: one-cycle pulse, stop bit sampled 0.
- `Busy` output 1: high while a frame is being received (any state except IDLE).

## Operation
- `RX_IN` passes through a 2-flop synchronizer (both flops reset to 1) → `rx_s`. A third flop `rx_d` holds the previous `rx_s` (reset 1).
- Counters:
  - `edge_cnt`, 0..PRESCALE-1, counts clocks within the current bit.
  - `bit_cnt` counts data bits 0..7.
- Let H = PRESCALE/2. Each bit is decided by a majority vote of `rx_s` at `edge_cnt` = H-1, H and H+1. The decision is made at `edge_cnt` = H+1.
- FSM states:
  - IDLE: on a falling edge (`rx_d`=1, `rx_s`=0), go to START with `edge_cnt`=0 in that cycle. Latch `PAR_EN`/`PAR_TYP`; they are held for the whole frame. Mid-frame changes are ignored.
  - START: at the decision point, majority 1 → glitch, return to IDLE with no output pulses. Majority 0 → DATA at the end of the bit (`edge_cnt`=PRESCALE-1).
  - DATA: shift the decided bit into an internal shift register, LSB first. After bit 7 → PARITY if the latched PAR_EN=1, else STOP.
  - PARITY: the decided bit must equal XOR(data) XOR PAR_TYP.
  - STOP: at the decision point, evaluate and go to IDLE immediately, without waiting for the end of the stop bit. This allows back-to-back frames.
- Frame result, registered, asserted the cycle after the stop decision:
  - No errors: `P_DATA` ← shift register, `DATA_VALID`=1.
  - Parity mismatch: `PAR_ERR`=1.
  - Stop bit = 0: `STP_ERR`=1.
  - Both errors: both flags pulse together.
  - Any error: `DATA_VALID` stays 0 and `P_DATA` holds its previous value.
- Start detection is edge-based. A line held low (break) after a stop error does not retrigger until it returns high and falls again.
- Reset (async, any state): FSM → IDLE, counters → 0, `P_DATA`=0x00, `DATA_VALID`=`PAR_ERR`=`STP_ERR`=`Busy`=0, synchronizer and `rx_d` → 1. A frame in progress is discarded. A line low when reset releases counts as a falling edge.

## Timing
- Cycle 0 is the first cycle `rx_s`=0. Cycle 0 is two clocks after `RX_IN` falls.
- Start decision at cycle H+1. Data bit k decided at (k+1)·PRESCALE + H + 1.
- Stop bit is bit index 9 without parity, 10 with parity. Stop decision at index·PRESCALE + H + 1.
- Result pulse one cycle later:
  - PAR_EN=0: cycle 9·PRESCALE + H + 2 (PRESCALE=8: cycle 78).
  - PAR_EN=1: cycle 10·PRESCALE + H + 2 (PRESCALE=8: cycle 86).
- `Busy` rises at cycle 0 and falls the cycle after the stop decision, the same cycle as the result pulse.
- Next frame: a start edge is accepted from the cycle FSM is in IDLE. A stop bit of exactly PRESCALE clocks is sufficient.
- Tolerance: majority sampling tolerates single-cycle glitches. Bit-rate mismatch is tolerated up to ±(H-2)/(frame bits·PRESCALE) of the bit period.

## Test plan
- PRESCALE=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0 → `DATA_VALID` pulse at cycle 86, `P_DATA`=0xA5, no error flags.
- PAR_EN=1, PAR_TYP=1, byte 0x3C sent with parity bit 0 (wrong; odd parity requires 1) → `PAR_ERR` pulse at cycle 86, no `DATA_VALID`, `P_DATA` keeps the prior 0xA5.
- PAR_EN=0, byte 0xFF with stop bit driven 0, then line held low 40 cycles, then high → one `STP_ERR` at cycle 78, no new start until the line goes high and falls again.
- 3-cycle low pulse on an idle line → START aborts at cycle H+1, `Busy` high for 6 cycles, no output pulses.
- Two back-to-back PAR_EN=0 frames 0x01, 0x80 with single-bit-period stops → two `DATA_VALID` pulses exactly 10·PRESCALE cycles apart, with `P_DATA` 0x01 then 0x80. Also run a TX→RX loopback of 256 random bytes → all match.
- `reset` asserted mid-DATA for 1 cycle → all outputs 0 immediately, no pulse for the aborted frame, next clean frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Serial-to-parallel UART receiver. Recovers frames of
// start(0), 8 data bits LSB first, optional parity, stop(1)
// from a line oversampled PRESCALE times per bit. Each bit is a 3-sample
// majority vote around the bit centre. Good bytes are presented on P_DATA
// with a one-cycle DATA_VALID strobe; parity and stop errors pulse
// PAR_ERR / STP_ERR instead.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous reset, active high
//   RX_IN      : serial line, idles high, asynchronous to clk
//   PAR_EN     : 1 = frame carries a parity bit (latched at frame start)
//   PAR_TYP    : 0 = even, 1 = odd parity (latched at frame start)
//   P_DATA     : last good received byte
//   DATA_VALID : one-cycle pulse when P_DATA is updated
//   PAR_ERR    : one-cycle pulse, parity mismatch
//   STP_ERR    : one-cycle pulse, stop bit sampled 0
//   Busy       : high while a frame is being received
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int PRESCALE = 8          // clocks per bit, even, >= 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic [7:0] P_DATA,
    output logic       DATA_VALID,
    output logic       PAR_ERR,
    output logic       STP_ERR,
    output logic       Busy
);

    localparam int CW = $clog2(PRESCALE);
    localparam int H  = PRESCALE / 2;

    localparam logic [CW-1:0] C_SMP0 = CW'(H - 1);        // first vote sample
    localparam logic [CW-1:0] C_SMP1 = CW'(H);            // second vote sample
    localparam logic [CW-1:0] C_DEC  = CW'(H + 1);        // third sample + decision
    localparam logic [CW-1:0] C_LAST = CW'(PRESCALE - 1); // last clock of a bit

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_rx_s;
    logic            r_rx_d;
    logic [CW-1:0]   r_edge_cnt;
    logic [2:0]      r_bit_cnt;
    logic            r_smp0;
    logic            r_smp1;
    logic [7:0]      r_shift;
    logic            r_par_en;
    logic            r_par_typ;
    logic            r_par_bad;
    logic [7:0]      r_p_data;
    logic            r_data_valid;
    logic            r_par_err;
    logic            r_stp_err;

    logic            w_fall;
    logic            w_vote;
    logic            w_dec;
    logic            w_last;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    // All three reset to the idle line level so reset itself never looks
    // like an edge, while a line that is low at release still does.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, which is what turns this into a real shift chain.
            r_sync1 <= RX_IN;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;
        end
    end

    assign w_fall = r_rx_d & ~r_rx_s;
    assign w_dec  = (r_edge_cnt == C_DEC);
    assign w_last = (r_edge_cnt == C_LAST);
    // Majority of the two stored samples and the live third sample.
    assign w_vote = (r_smp0 & r_smp1) | (r_smp0 & r_rx_s) | (r_smp1 & r_rx_s);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_edge_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_smp0       <= 1'b1;
            r_smp1       <= 1'b1;
            r_shift      <= '0;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_par_bad    <= 1'b0;
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            // NOTE: result strobes default low every cycle so each one is a
            // single-cycle pulse without per-state clearing.
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;

            if (r_state != ST_IDLE) begin
                r_edge_cnt <= w_last ? '0 : r_edge_cnt + 1'b1;
                if (r_edge_cnt == C_SMP0) r_smp0 <= r_rx_s;
                if (r_edge_cnt == C_SMP1) r_smp1 <= r_rx_s;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        // The edge cycle itself is clock 0 of the start bit.
                        r_state    <= ST_START;
                        r_edge_cnt <= CW'(1);
                        r_bit_cnt  <= '0;
                        r_par_en   <= PAR_EN;
                        r_par_typ  <= PAR_TYP;
                        r_par_bad  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_dec && w_vote) begin
                        // Start bit did not hold low: treat as a glitch.
                        r_state    <= ST_IDLE;
                        r_edge_cnt <= '0;
                    end else if (w_last) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_dec) r_shift <= {w_vote, r_shift[7:1]};
                    if (w_last) begin
                        if (r_bit_cnt == 3'd7)
                            r_state <= r_par_en ? ST_PARITY : ST_STOP;
                        else
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end
                ST_PARITY: begin
                    if (w_dec) r_par_bad <= (w_vote != (^r_shift ^ r_par_typ));
                    if (w_last) r_state <= ST_STOP;
                end
                ST_STOP: begin
                    // Leave at the decision point so a following start bit
                    // right after a one-period stop is not missed.
                    if (w_dec) begin
                        r_state    <= ST_IDLE;
                        r_edge_cnt <= '0;
                        r_par_err  <= r_par_bad;
                        r_stp_err  <= ~w_vote;
                        if (!r_par_bad && w_vote) begin
                            r_p_data     <= r_shift;
                            r_data_valid <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign P_DATA     = r_p_data;
    assign DATA_VALID = r_data_valid;
    assign PAR_ERR    = r_par_err;
    assign STP_ERR    = r_stp_err;
    // Busy covers the detection cycle too, since that cycle already counts
    // as the first clock of the start bit.
    assign Busy       = (r_state != ST_IDLE) | w_fall;

endmodule
